// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Program counter and instruction-fetch stage. Fetches one
//                instruction per req/ack handshake, holds it for an execute
//                window, then advances the PC using the controller's
//                {jr, j, branch} select. Counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             o_imem_req,
  output logic [31:0]      o_imem_addr,
  input  logic             i_imem_ack,
  input  logic [31:0]      i_imem_rdata,
  output logic [31:0]      o_instr,
  output logic             o_instr_valid,
  input  logic             i_hold,
  input  logic [2:0]       i_pc_next_c,
  input  logic [31:0]      i_imm_ext,
  input  logic [31:0]      i_jr_addr,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_pc_plus4,
  output logic             o_addr_err,
  output logic [CNT_W-1:0] o_retired_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_imem_req;
  logic             r_instr_valid;
  logic             r_addr_err;
  logic [CNT_W-1:0] r_retired_cnt;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_next_pc;
  logic             w_jr_misaligned;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_jr_misaligned = i_pc_next_c[2] && (i_jr_addr[1:0] != 2'b00);

  // Next-PC select: jr has highest priority, then j, then branch, else +4.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (i_pc_next_c[2]) begin
      w_next_pc = {i_jr_addr[31:2], 2'b00};
    end else if (i_pc_next_c[1]) begin
      w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    end else if (i_pc_next_c[0]) begin
      w_next_pc = w_pc_plus4 + (i_imm_ext << 2);
    end
  end

  // Fetch/execute sequencer with all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_addr_err    <= 1'b0;
      r_retired_cnt <= '0;
    end else begin
      // addr_err is a single-cycle pulse unless re-armed below.
      r_addr_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_imem_req <= 1'b1;
          r_state    <= FETCH;
        end
        FETCH: begin
          if (i_imem_ack) begin
            r_instr       <= i_imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= EXEC;
          end
        end
        EXEC: begin
          if (!i_hold) begin
            r_pc          <= w_next_pc;
            r_retired_cnt <= r_retired_cnt + 1'b1;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
            r_addr_err    <= w_jr_misaligned;
            r_state       <= FETCH;
          end
        end
        default: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_state       <= IDLE;
        end
      endcase
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_addr_err    = r_addr_err;
  assign o_retired_cnt = r_retired_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Directed self-checking bench for pc_fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        hold;
  logic [2:0]  pc_next_c;
  logic [31:0] imm_ext;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;
  logic [31:0] retired_cnt;

  int checks   = 0;
  int failures = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_rdata  (imem_rdata),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .i_hold        (hold),
    .i_pc_next_c   (pc_next_c),
    .i_imm_ext     (imm_ext),
    .i_jr_addr     (jr_addr),
    .o_pc          (pc),
    .o_pc_plus4    (pc_plus4),
    .o_addr_err    (addr_err),
    .o_retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for an execute window, then jr to a target address.
  task automatic goto_pc(input logic [31:0] target);
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!instr_valid) begin
      failures++;
      $display("FAIL goto_timeout instr_valid=%0b required=1", instr_valid);
    end
    hold = 1'b0; pc_next_c = 3'b100; jr_addr = target;
    tick();
    pc_next_c = 3'b000;
    checks++;
    if (pc !== target) begin
      failures++;
      $display("FAIL goto_pc pc=%h required=%h", pc, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; hold = 1'b0;
    pc_next_c = 3'b000; imm_ext = 32'd0; jr_addr = 32'd0;
    repeat (3) tick();
    checks++;
    if ({imem_req, instr_valid, addr_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags req/valid/err=%b required=000", {imem_req, instr_valid, addr_err});
    end
    checks++;
    if (pc !== 32'd0 || imem_addr !== 32'd0 || instr !== 32'd0 || retired_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_values pc=%h addr=%h instr=%h cnt=%0d required all 0", pc, imem_addr, instr, retired_cnt);
    end
    rst_n = 1'b1;
    imem_ack = 1'b1;
  endtask

  task automatic test_zero_wait();
    tick();  // IDLE -> FETCH
    for (int k = 0; k < 4; k++) begin
      imem_rdata = 32'h1000_0000 + k;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4*k) || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL zw_fetch k=%0d req=%b addr=%h valid=%b required 1/%h/0", k, imem_req, imem_addr, instr_valid, 32'(4*k));
      end
      checks++;
      if (pc_plus4 !== 32'(4*k + 4)) begin
        failures++;
        $display("FAIL zw_pc_plus4 k=%0d got=%h required=%h", k, pc_plus4, 32'(4*k + 4));
      end
      tick();
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'h1000_0000 + k) begin
        failures++;
        $display("FAIL zw_exec k=%0d valid=%b req=%b instr=%h required 1/0/%h", k, instr_valid, imem_req, instr, 32'h1000_0000 + k);
      end
      tick();
    end
    checks++;
    if (retired_cnt !== 32'd4) begin
      failures++;
      $display("FAIL zw_retired got=%0d required=4", retired_cnt);
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_wait_hold();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL wait_fetch i=%0d req=%b addr=%h valid=%b required 1/00000010/0", i, imem_req, imem_addr, instr_valid);
      end
      if (i == 3) begin
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_0010; hold = 1'b1;
      end
      tick();
    end
    // EXEC window held for two cycles; select and ack changes must be ignored.
    imem_rdata = 32'hDEAD_BEEF; pc_next_c = 3'b100; jr_addr = 32'h888;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'h10 || instr !== 32'hCAFE_0010 || retired_cnt !== 32'd4) begin
        failures++;
        $display("FAIL hold_exec i=%0d valid=%b pc=%h instr=%h cnt=%0d required 1/10/cafe0010/4", i, instr_valid, pc, instr, retired_cnt);
      end
      if (i == 2) begin
        hold = 1'b0; pc_next_c = 3'b000;
      end
      tick();
    end
    checks++;
    if (pc !== 32'h14 || instr_valid !== 1'b0 || retired_cnt !== 32'd5) begin
      failures++;
      $display("FAIL hold_release pc=%h valid=%b cnt=%0d required 14/0/5", pc, instr_valid, retired_cnt);
    end
  endtask

  task automatic test_branch();
    goto_pc(32'h100);
    tick();
    pc_next_c = 3'b001; imm_ext = 32'd3;
    tick();
    pc_next_c = 3'b000;
    checks++;
    if (pc !== 32'h110) begin
      failures++;
      $display("FAIL branch_fwd pc=%h required=00000110", pc);
    end
    tick();
    pc_next_c = 3'b001; imm_ext = 32'hFFFF_FFFE;
    tick();
    pc_next_c = 3'b000;
    checks++;
    if (pc !== 32'h10C || retired_cnt !== 32'd8) begin
      failures++;
      $display("FAIL branch_bwd pc=%h cnt=%0d required 0000010c/8", pc, retired_cnt);
    end
  endtask

  task automatic test_jump();
    goto_pc(32'h4000_0020);
    imem_rdata = 32'h0800_0040;
    tick();
    pc_next_c = 3'b011; imm_ext = 32'd5;
    tick();
    pc_next_c = 3'b000;
    checks++;
    if (pc !== 32'h4000_0100) begin
      failures++;
      $display("FAIL jump_pri pc=%h required=40000100", pc);
    end
    tick();
    pc_next_c = 3'b111; jr_addr = 32'h200;
    tick();
    pc_next_c = 3'b000;
    checks++;
    if (pc !== 32'h200 || addr_err !== 1'b0) begin
      failures++;
      $display("FAIL jr_pri pc=%h err=%b required 00000200/0", pc, addr_err);
    end
  endtask

  task automatic test_misaligned();
    tick();
    pc_next_c = 3'b100; jr_addr = 32'h0000_0303;
    tick();
    pc_next_c = 3'b000; imem_ack = 1'b0;
    checks++;
    if (pc !== 32'h300 || imem_addr !== 32'h300 || addr_err !== 1'b1 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL misalign_first pc=%h addr=%h err=%b req=%b required 300/300/1/1", pc, imem_addr, addr_err, imem_req);
    end
    tick();
    imem_ack = 1'b1;
    checks++;
    if (addr_err !== 1'b0 || imem_addr !== 32'h300) begin
      failures++;
      $display("FAIL misalign_pulse err=%b addr=%h required 0/300", addr_err, imem_addr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || addr_err !== 1'b0) begin
      failures++;
      $display("FAIL misalign_exec valid=%b err=%b required 1/0", instr_valid, addr_err);
    end
  endtask

  task automatic test_wrap_reset();
    goto_pc(32'hFFFF_FFFC);
    checks++;
    if (pc_plus4 !== 32'd0) begin
      failures++;
      $display("FAIL wrap_plus4 got=%h required=00000000", pc_plus4);
    end
    tick();
    tick();
    checks++;
    if (pc !== 32'd0 || retired_cnt !== 32'd14) begin
      failures++;
      $display("FAIL wrap_pc pc=%h cnt=%0d required 0/14", pc, retired_cnt);
    end
    tick();
    tick();
    imem_ack = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h4 || imem_req !== 1'b1 || retired_cnt !== 32'd15) begin
      failures++;
      $display("FAIL pre_reset pc=%h req=%b cnt=%0d required 4/1/15", pc, imem_req, retired_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 32'd0 || retired_cnt !== 32'd0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset req=%b pc=%h cnt=%0d valid=%b required 0/0/0/0", imem_req, pc, retired_cnt, instr_valid);
    end
    imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'd0) begin
      failures++;
      $display("FAIL reset_ack_ignored req=%b valid=%b instr=%h required 0/0/0", imem_req, instr_valid, instr);
    end
    imem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_fetch req=%b addr=%h valid=%b required 1/0/0", imem_req, imem_addr, instr_valid);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || retired_cnt !== 32'd0) begin
      failures++;
      $display("FAIL post_reset_exec valid=%b instr=%h cnt=%0d required 1/12345678/0", instr_valid, instr, retired_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_hold();
    test_branch();
    test_jump();
    test_misaligned();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout time=%0t required finish before 100000", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage directly upstream of the main controller.
- Holds the PC and fetches each instruction from instruction memory over a req/ack handshake, then presents it to decode/control for one execute window.
- In that window it computes the next PC from the controller's 3-bit next-PC select {jr, j, branch}.
- Also keeps a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ack  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  latched instruction to decode/control.
- instr_valid  out  1  instr is in its execute window.
- hold  in  1  core stall; extends the execute window.
- pc_next_c  in  3  {jr_c, j_c, branch_c} from controller; sampled only in EXEC.
- imm_ext  in  32  sign-extended immediate (branch offset, words).
- jr_addr  in  32  register-file value for jr.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4 (for jal link); combinational from pc.
- addr_err  out  1  one-cycle pulse: misaligned jr target.
- retired_cnt  out  CNT_W  count of completed instructions.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, instr=0, instr_valid=0, addr_err=0, retired_cnt=0.
- All outputs are registered except pc_plus4 and imem_addr (=pc).
- FSM states: IDLE, FETCH, EXEC.
- IDLE: entered only from reset. Goes to FETCH on the first clock edge after rst_n deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable until imem_ack is sampled 1.
  - An ack in the first FETCH cycle is legal (zero wait).
  - On ack: instr<=imem_rdata, instr_valid<=1, go to EXEC.
  - Wait states are unbounded.
- EXEC:
  - imem_req=0; instr_valid=1.
  - If hold=1: stay in EXEC; pc, instr and retired_cnt are unchanged.
  - If hold=0: pc<=next_pc, retired_cnt<=retired_cnt+1, instr_valid<=0, go to FETCH. Minimum instruction latency is therefore 2 cycles (FETCH with immediate ack, then EXEC).
- Handshake rules:
  - imem_ack is ignored outside FETCH.
  - pc_next_c, imm_ext and jr_addr are ignored outside EXEC, and ignored in EXEC while hold=1.
- next_pc priority (exactly one source; multiple bits set resolve by priority):
  - pc_next_c[2] (jr): {jr_addr[31:2], 2'b00}.
  - else pc_next_c[1] (j): {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else pc_next_c[0] (branch): pc_plus4 + (imm_ext << 2).
  - else: pc_plus4.
- Arithmetic and width rules:
  - All PC arithmetic is 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
  - retired_cnt wraps to 0 on overflow with no flag.
- Misaligned jr: if jr is selected and jr_addr[1:0]!=0 when EXEC exits, addr_err pulses 1 for exactly one cycle (the first FETCH cycle). The low bits are cleared and fetch continues.
- Reset mid-operation: assertion in any state returns immediately (asynchronously) to the reset values. imem_req drops without waiting for ack, and a late ack after reset is ignored.

Test Plan:
- Reset then zero-wait ack: rst_n low 3 cycles, release; imem_ack tied 1, pc_next_c=0 -> addresses 0,4,8,C on successive FETCH cycles; instr_valid high every 2nd cycle; retired_cnt=4 after 8 cycles.
- Wait states and hold: ack after 3 wait cycles at pc=0x10, then hold=1 for 2 EXEC cycles -> imem_addr stable 0x10 for all 4 FETCH cycles; instr_valid high 3 cycles; pc stays 0x10 until hold drops; then pc=0x14.
- Branch, forward and backward: pc=0x100, branch_c=1, imm_ext=3 -> next pc 0x110. Then imm_ext=32'hFFFF_FFFE at pc=0x110 -> next pc 0x10C.
- Jump and priority: pc=0x4000_0020, instr[25:0]=26'h000_0040, pc_next_c=3'b011 -> pc=0x4000_0100 (j beats branch). pc_next_c=3'b111, jr_addr=0x200 -> pc=0x200.
- Misaligned jr: jr_addr=0x0000_0303 -> pc=0x300; addr_err high exactly 1 cycle; fetch proceeds at 0x300.
- Reset mid-fetch and wrap: pc=0xFFFF_FFFC, pc_next_c=0 -> pc=0. Then assert rst_n mid-FETCH before ack -> imem_req=0 same cycle, pc=RESET_PC, retired_cnt=0; an ack arriving during reset is ignored.
